// File: rtl/lru_pkg.sv
// Shared constants and helpers for the matrix-based LRU tracker.
// Holds the default geometry, the width helper and the reset-order row generator.
package lru_pkg;

  localparam int LRU_DEF_WAYS = 4;
  localparam int LRU_DEF_SETS = 16;
  localparam int LRU_MAX_WAYS = 8;

  function automatic int lru_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Full (diagonal-included) reset row for way i: more recent than every lower way.
  function automatic logic [LRU_MAX_WAYS-1:0] lru_reset_row(input int i);
    logic [LRU_MAX_WAYS-1:0] r;
    r = '0;
    for (int j = 0; j < LRU_MAX_WAYS; j++) begin
      if (j < i) r[j] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lru_matrix_if.sv
// Access / invalidate / victim-query bundle for lru_matrix.
// Handshake: every *_vld / vic_req is a single-cycle strobe with no back-pressure; vic_vld follows vic_req by exactly one cycle.
interface lru_matrix_if
  import lru_pkg::*;
#(
  parameter int WAYS = LRU_DEF_WAYS,
  parameter int SETS = LRU_DEF_SETS
);
  localparam int WAY_W = lru_clog2(WAYS);
  localparam int SET_W = lru_clog2(SETS);

  logic             touch_vld;
  logic [SET_W-1:0] touch_set;
  logic [WAY_W-1:0] touch_way;
  logic             inv_vld;
  logic [SET_W-1:0] inv_set;
  logic [WAY_W-1:0] inv_way;
  logic             vic_req;
  logic [SET_W-1:0] vic_set;
  logic [WAYS-1:0]  vic_lock;
  logic             vic_vld;
  logic [WAY_W-1:0] vic_way;
  logic             vic_none;

  modport master (
    output touch_vld, touch_set, touch_way,
    output inv_vld, inv_set, inv_way,
    output vic_req, vic_set, vic_lock,
    input  vic_vld, vic_way, vic_none
  );

  modport slave (
    input  touch_vld, touch_set, touch_way,
    input  inv_vld, inv_set, inv_way,
    input  vic_req, vic_set, vic_lock,
    output vic_vld, vic_way, vic_none
  );

endinterface

// File: rtl/lru_victim_select.sv
// Combinational victim pick: the unlocked way whose row, masked by the unlocked set, is all zero.
// A total recency order guarantees at most one such way, so the encode is a plain OR-style scan.
module lru_victim_select
  import lru_pkg::*;
#(
  parameter int WAYS = LRU_DEF_WAYS
) (
  input  logic [WAYS-1:0][WAYS-1:0]     rows,
  input  logic [WAYS-1:0]               lock,
  output logic [lru_clog2(WAYS)-1:0]    way,
  output logic                          none
);
  localparam int WAY_W = lru_clog2(WAYS);

  logic [WAYS-1:0] cand;

  always_comb begin
    cand = '0;
    way  = '0;
    none = &lock;
    for (int v = 0; v < WAYS; v++) begin
      cand[v] = !lock[v] && ((rows[v] & ~lock) == '0);
    end
    for (int v = 0; v < WAYS; v++) begin
      if (cand[v]) way = WAY_W'(v);
    end
  end

endmodule

// File: rtl/lru_matrix.sv
// Per-set WAYS x WAYS age-matrix LRU tracker with touch, invalidate and registered victim query.
// Rows are stored compressed (diagonal dropped) and expanded to full width only for update/select.
module lru_matrix
  import lru_pkg::*;
#(
  parameter int WAYS = LRU_DEF_WAYS,
  parameter int SETS = LRU_DEF_SETS
) (
  input  logic         clk,
  input  logic         reset,
  lru_matrix_if.slave  bus
);
  localparam int WAY_W = lru_clog2(WAYS);
  localparam int SET_W = lru_clog2(SETS);

  typedef logic [WAYS-1:0] frow_t;
  typedef logic [WAYS-2:0] crow_t;

  logic [SETS-1:0][WAYS-1:0][WAYS-2:0] mat_q, mat_d;
  logic [WAYS-1:0][WAYS-1:0]           full;
  logic [WAYS-1:0][WAYS-1:0]           vic_rows;
  logic                                touch_ok, inv_ok;
  logic [WAY_W-1:0]                    sel_way;
  logic                                sel_none;
  logic                                vic_vld_q, vic_vld_d;
  logic [WAY_W-1:0]                    vic_way_q, vic_way_d;
  logic                                vic_none_q, vic_none_d;

  function automatic frow_t low_mask(input int i);
    return frow_t'((frow_t'(1) << i) - frow_t'(1));
  endfunction

  // Compressed bit k maps to column k below the diagonal and column k+1 above it.
  function automatic frow_t expand(input int i, input crow_t r);
    frow_t rw;
    rw = frow_t'(r);
    return (rw & low_mask(i)) | ((rw & ~low_mask(i)) << 1);
  endfunction

  function automatic crow_t compress(input int i, input frow_t f);
    return crow_t'((f & low_mask(i)) | ((f >> 1) & ~low_mask(i)));
  endfunction

  function automatic crow_t reset_row(input int i);
    return compress(i, frow_t'(lru_reset_row(i)));
  endfunction

  assign touch_ok = bus.touch_vld && (32'(bus.touch_way) < WAYS);
  assign inv_ok   = bus.inv_vld   && (32'(bus.inv_way)   < WAYS);

  // Touch is applied before invalidate so a same-way collision ends LRU.
  always_comb begin
    mat_d    = mat_q;
    full     = '0;
    vic_rows = '0;
    for (int s = 0; s < SETS; s++) begin
      for (int i = 0; i < WAYS; i++) begin
        full[i] = expand(i, mat_q[s][i]);
      end
      if (touch_ok && (bus.touch_set == SET_W'(s))) begin
        full[bus.touch_way] = '1;
        for (int j = 0; j < WAYS; j++) full[j][bus.touch_way] = 1'b0;
      end
      if (inv_ok && (bus.inv_set == SET_W'(s))) begin
        full[bus.inv_way] = '0;
        for (int j = 0; j < WAYS; j++) full[j][bus.inv_way] = 1'b1;
        full[bus.inv_way][bus.inv_way] = 1'b0;
      end
      for (int i = 0; i < WAYS; i++) begin
        mat_d[s][i] = compress(i, full[i]);
      end
      if (bus.vic_set == SET_W'(s)) vic_rows = full;
    end
  end

  lru_victim_select #(.WAYS(WAYS)) u_sel (
    .rows (vic_rows),
    .lock (bus.vic_lock),
    .way  (sel_way),
    .none (sel_none)
  );

  always_comb begin
    vic_vld_d  = bus.vic_req;
    vic_way_d  = vic_way_q;
    vic_none_d = vic_none_q;
    if (bus.vic_req) begin
      vic_way_d  = sel_way;
      vic_none_d = sel_none;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SETS; s++) begin
        for (int i = 0; i < WAYS; i++) begin
          mat_q[s][i] <= reset_row(i);
        end
      end
      vic_vld_q  <= 1'b0;
      vic_way_q  <= '0;
      vic_none_q <= 1'b0;
    end else begin
      mat_q      <= mat_d;
      vic_vld_q  <= vic_vld_d;
      vic_way_q  <= vic_way_d;
      vic_none_q <= vic_none_d;
    end
  end

  assign bus.vic_vld  = vic_vld_q;
  assign bus.vic_way  = vic_way_q;
  assign bus.vic_none = vic_none_q;

endmodule

// File: doc/lru_matrix.md
LRU_MATRIX -- requirements
Module: lru_matrix

Interface
REQ-001 Parameter WAYS, default 4, ways per set (2..8).
REQ-002 Parameter SETS, default 16, number of sets (power of 2, >=2).
REQ-003 Parameter WAY_W = clog2(WAYS), SET_W = clog2(SETS), both derived and not overridable.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 touch_vld  input  1  access strobe; marks touch_way of touch_set as MRU.
REQ-007 touch_set  input  SET_W  set index of the access.
REQ-008 touch_way  input  WAY_W  way index of the access.
REQ-009 inv_vld  input  1  invalidate strobe; demotes inv_way of inv_set to LRU.
REQ-010 inv_set  input  SET_W  set index of the invalidate.
REQ-011 inv_way  input  WAY_W  way index of the invalidate.
REQ-012 vic_req  input  1  victim query strobe.
REQ-013 vic_set  input  SET_W  set being queried.
REQ-014 vic_lock  input  WAYS  per-way exclusion mask for the query; 1 = not eligible.
REQ-015 vic_vld  output  1  victim result valid, one cycle after vic_req.
REQ-016 vic_way  output  WAY_W  least-recently-used eligible way.
REQ-017 vic_none  output  1  all ways locked; no victim.

Function
REQ-018 Each set SHALL hold a WAYS x WAYS age matrix M; M[i][j]=1 means way i is more recent than way j; diagonal bits are not stored.
REQ-019 Touch of way w SHALL set row w to all ones and clear column w in one clock edge, making w MRU.
REQ-020 Invalidate of way w SHALL clear row w and set column w in one clock edge, making w LRU.
REQ-021 Touch and invalidate to different sets in one cycle SHALL both take effect.
REQ-022 Touch and invalidate to the same set and different ways SHALL apply the touch first and then the invalidate.
REQ-023 Touch and invalidate to the same set and same way SHALL leave the way LRU (invalidate wins).
REQ-024 Out-of-range way indices (>= WAYS) SHALL be ignored with no state change.
REQ-025 Victim way SHALL be the way v with vic_lock[v]=0 whose row masked by ~vic_lock is zero; ties are impossible by construction.
REQ-026 Victim evaluation SHALL use the post-update matrix of vic_set, so a same-cycle touch/invalidate is visible (write-first).
REQ-027 vic_vld, vic_way and vic_none SHALL be registered, with latency exactly 1 cycle; back-to-back vic_req every cycle SHALL be supported.
REQ-028 With no vic_req, vic_vld SHALL be 0 and vic_way/vic_none SHALL hold their last values.
REQ-029 If vic_lock is all ones: vic_none=1 and vic_way=0.

Reset
REQ-030 Asserting reset (low) SHALL asynchronously set every set's matrix to M[i][j]=1 iff i>j (way 0 LRU, way WAYS-1 MRU).
REQ-031 Reset SHALL clear vic_vld, vic_way and vic_none to 0.
REQ-032 Requests in the reset cycle SHALL be discarded; deassertion is synchronised externally.

Structure
REQ-033 Shared package lru_pkg SHALL hold the clog2 function, the default WAYS/SETS constants and the reset-matrix generator.
REQ-034 Sub-module lru_victim_select (combinational: masked row zero-detect and one-hot-to-index encode) SHALL be instantiated once.
REQ-035 Matrix storage SHALL be flops, SETS*WAYS*(WAYS-1) bits; no RAM macro.

Verification
REQ-036 Reset, then vic_req set 3 with lock 0000 -> next cycle vic_vld=1, vic_way=0, vic_none=0.
REQ-037 Set 5: touch ways 0,1,2,3 in order, then query -> vic_way=0; touch 0, query -> vic_way=1.
REQ-038 Set 2 after reset: vic_lock=0001 -> vic_way=1; vic_lock=1111 -> vic_none=1, vic_way=0.
REQ-039 Set 7: touch way 3 and vic_req in the same cycle after reset -> vic_way=0; invalidate way 2 plus query same cycle -> vic_way=2.
REQ-040 Same cycle touch way 1 and invalidate way 1 in set 0 -> following query returns vic_way=1.
REQ-041 Assert reset mid-sequence with pending vic_req -> vic_vld=0 immediately; all sets return to the REQ-030 order.
